// File: rtl/puck_ctl_if.sv
// Puck controller bus: frame timing, player input and puck/score outputs.
//   master : drives vsync_in, start, paddle_xpos, paddle_ypos; reads the rest
//   slave  : the puck controller itself
interface puck_ctl_if;
  logic        vsync_in;
  logic        start;
  logic [11:0] paddle_xpos;
  logic [11:0] paddle_ypos;
  logic [11:0] puck_xpos;
  logic [11:0] puck_ypos;
  logic [2:0]  score_p1;
  logic [2:0]  score_p2;
  logic        goal;
  logic        game_over;

  modport master (
    output vsync_in, start, paddle_xpos, paddle_ypos,
    input  puck_xpos, puck_ypos, score_p1, score_p2, goal, game_over
  );

  modport slave (
    input  vsync_in, start, paddle_xpos, paddle_ypos,
    output puck_xpos, puck_ypos, score_p1, score_p2, goal, game_over
  );
endinterface

// File: rtl/puck_ctl.sv
// Air-hockey puck controller. Advances the puck once per video frame (rising
// edge of vsync_in), bounces it off walls and the player paddle, detects goals,
// keeps score and runs the serve / goal-hold / game-over sequence.
// Ports:
//   clk  : pixel-domain clock
//   rst  : synchronous active-high reset
//   bus  : puck_ctl_if.slave (vsync_in, start, paddle_xpos/ypos in;
//          puck_xpos/ypos, score_p1/p2, goal, game_over out, all registered)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | puck parked at centre, waiting for start on a frame tick
// PLAY      | puck moving; goals, paddle hits and wall bounces evaluated
// HOLD      | puck frozen at centre for GOAL_HOLD frames after a goal
// GAME_OVER | a player reached SCORE_MAX; start begins a new game
module puck_ctl #(
  parameter int SCREEN_W  = 1024,
  parameter int SCREEN_H  = 768,
  parameter int PUCK_R    = 16,
  parameter int PADDLE_R  = 24,
  parameter int GOAL_TOP  = 284,
  parameter int GOAL_BOT  = 484,
  parameter int VEL_INIT  = 4,
  parameter int GOAL_HOLD = 60,
  parameter int SCORE_MAX = 7
) (
  input logic       clk,
  input logic       rst,
  puck_ctl_if.slave bus
);
  localparam logic signed [12:0] X_LO  = 13'(PUCK_R);
  localparam logic signed [12:0] X_HI  = 13'(SCREEN_W - 1 - PUCK_R);
  localparam logic signed [12:0] Y_LO  = 13'(PUCK_R);
  localparam logic signed [12:0] Y_HI  = 13'(SCREEN_H - 1 - PUCK_R);
  localparam logic signed [12:0] HIT_D = 13'(PUCK_R + PADDLE_R);
  localparam logic [11:0] X_MID     = 12'(SCREEN_W / 2);
  localparam logic [11:0] Y_MID     = 12'(SCREEN_H / 2);
  localparam logic [11:0] MOUTH_TOP = 12'(GOAL_TOP);
  localparam logic [11:0] MOUTH_BOT = 12'(GOAL_BOT);
  localparam logic signed [4:0] VEL = 5'(VEL_INIT);
  localparam logic [2:0] S_MAX = 3'(SCORE_MAX);
  localparam int HW = $clog2(GOAL_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(GOAL_HOLD - 1);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, GAME_OVER} state_t;

  state_t           state;
  logic             vsync_q;
  logic [11:0]      x, y;
  logic signed [4:0] vx, vy;
  logic [2:0]       s1, s2;
  logic [HW-1:0]    hold_cnt;
  logic             goal_left;
  logic             goal_q, over_q;

  logic              tick, in_mouth, goal_l, goal_rt, hit;
  logic signed [12:0] nx, ny, dx, dy, adx, ady;
  logic signed [4:0]  mag_x, mag_y, hit_vx, hit_vy;

  assign bus.puck_xpos = x;
  assign bus.puck_ypos = y;
  assign bus.score_p1  = s1;
  assign bus.score_p2  = s2;
  assign bus.goal      = goal_q;
  assign bus.game_over = over_q;

  always_comb begin
    tick     = bus.vsync_in & ~vsync_q;
    nx       = $signed({1'b0, x}) + $signed({{8{vx[4]}}, vx});
    ny       = $signed({1'b0, y}) + $signed({{8{vy[4]}}, vy});
    in_mouth = (y >= MOUTH_TOP) && (y <= MOUTH_BOT);
    goal_l   = (nx <= X_LO) && in_mouth;
    goal_rt  = (nx >= X_HI) && in_mouth;
    // Box test against the paddle, using the current (not advanced) position.
    dx       = $signed({1'b0, x}) - $signed({1'b0, bus.paddle_xpos});
    dy       = $signed({1'b0, y}) - $signed({1'b0, bus.paddle_ypos});
    adx      = dx[12] ? -dx : dx;
    ady      = dy[12] ? -dy : dy;
    hit      = (adx < HIT_D) && (ady < HIT_D);
    // A stalled axis is kicked to serve speed so the puck always leaves the paddle.
    mag_x    = vx[4] ? -vx : vx;
    mag_y    = vy[4] ? -vy : vy;
    if (mag_x == 5'sd0) mag_x = VEL;
    if (mag_y == 5'sd0) mag_y = VEL;
    hit_vx   = (x >= bus.paddle_xpos) ? mag_x : -mag_x;
    hit_vy   = (y >= bus.paddle_ypos) ? mag_y : -mag_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vsync_q   <= 1'b0;
      x         <= X_MID;
      y         <= Y_MID;
      vx        <= '0;
      vy        <= '0;
      s1        <= '0;
      s2        <= '0;
      hold_cnt  <= '0;
      goal_left <= 1'b0;
      goal_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      vsync_q <= bus.vsync_in;
      goal_q  <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: if (bus.start) begin
            vx    <= VEL;
            vy    <= VEL;
            state <= PLAY;
          end
          PLAY: begin
            if (goal_l || goal_rt) begin
              if (goal_l) s2 <= (s2 == S_MAX) ? s2 : s2 + 3'd1;
              else        s1 <= (s1 == S_MAX) ? s1 : s1 + 3'd1;
              goal_left <= goal_l;
              goal_q    <= 1'b1;
              x         <= X_MID;
              y         <= Y_MID;
              vx        <= '0;
              vy        <= '0;
              hold_cnt  <= '0;
              state     <= HOLD;
            end else if (hit) begin
              vx <= hit_vx;
              vy <= hit_vy;
            end else begin
              if (nx < X_LO) begin
                x  <= X_LO[11:0];
                vx <= -vx;
              end else if (nx > X_HI) begin
                x  <= X_HI[11:0];
                vx <= -vx;
              end else begin
                x <= nx[11:0];
              end
              if (ny < Y_LO) begin
                y  <= Y_LO[11:0];
                vy <= -vy;
              end else if (ny > Y_HI) begin
                y  <= Y_HI[11:0];
                vy <= -vy;
              end else begin
                y <= ny[11:0];
              end
            end
          end
          HOLD: begin
            hold_cnt <= hold_cnt + HW'(1);
            if (hold_cnt == HOLD_LAST) begin
              if (s1 == S_MAX || s2 == S_MAX) begin
                over_q <= 1'b1;
                state  <= GAME_OVER;
              end else begin
                // Serve toward the player who just conceded.
                vx    <= goal_left ? -VEL : VEL;
                vy    <= VEL;
                state <= PLAY;
              end
            end
          end
          GAME_OVER: if (bus.start) begin
            s1     <= '0;
            s2     <= '0;
            vx     <= VEL;
            vy     <= VEL;
            over_q <= 1'b0;
            state  <= PLAY;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_puck_ctl.sv
// Self-checking bench for puck_ctl: directed scenarios plus randomized play,
// checked against a frame-level behavioural model of the puck game.
module tb_puck_ctl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puck_ctl_if bus ();
  puck_ctl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic g1, g2;

  localparam int M_IDLE = 0, M_PLAY = 1, M_HOLD = 2, M_OVER = 3;
  localparam int FAR = 2000;
  int m_x, m_y, m_vx, m_vy, m_mode, m_cnt, m_s1, m_s2;
  bit m_left, m_goal;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_reset();
    m_x = 512; m_y = 384; m_vx = 0; m_vy = 0; m_mode = M_IDLE;
    m_cnt = 0; m_s1 = 0; m_s2 = 0; m_left = 0; m_goal = 0;
  endfunction

  function automatic void model_goal(bit left);
    m_goal = 1; m_left = left; m_x = 512; m_y = 384;
    m_vx = 0; m_vy = 0; m_cnt = 0; m_mode = M_HOLD;
  endfunction

  // One frame of the game, from the rules: goal > paddle > walls > move.
  function automatic void model_tick(bit st, int px, int py);
    int nx, ny, mx, my;
    m_goal = 0;
    case (m_mode)
      M_IDLE: if (st) begin m_vx = 4; m_vy = 4; m_mode = M_PLAY; end
      M_PLAY: begin
        nx = m_x + m_vx;
        ny = m_y + m_vy;
        if (nx <= 16 && m_y >= 284 && m_y <= 484) begin
          if (m_s2 < 7) m_s2++;
          model_goal(1);
        end else if (nx >= 1007 && m_y >= 284 && m_y <= 484) begin
          if (m_s1 < 7) m_s1++;
          model_goal(0);
        end else if (iabs(m_x - px) < 40 && iabs(m_y - py) < 40) begin
          mx = (m_vx == 0) ? 4 : iabs(m_vx);
          my = (m_vy == 0) ? 4 : iabs(m_vy);
          m_vx = (m_x >= px) ? mx : -mx;
          m_vy = (m_y >= py) ? my : -my;
        end else begin
          if (nx < 16) begin m_x = 16; m_vx = -m_vx; end
          else if (nx > 1007) begin m_x = 1007; m_vx = -m_vx; end
          else m_x = nx;
          if (ny < 16) begin m_y = 16; m_vy = -m_vy; end
          else if (ny > 751) begin m_y = 751; m_vy = -m_vy; end
          else m_y = ny;
        end
      end
      M_HOLD: begin
        if (m_cnt == 59) begin
          if (m_s1 == 7 || m_s2 == 7) m_mode = M_OVER;
          else begin m_vx = m_left ? -4 : 4; m_vy = 4; m_mode = M_PLAY; end
        end
        m_cnt++;
      end
      default: if (st) begin
        m_s1 = 0; m_s2 = 0; m_vx = 4; m_vy = 4; m_mode = M_PLAY;
      end
    endcase
  endfunction

  // Paddle placement that pushes the puck toward side sx while keeping y
  // inside the goal mouth; parks the paddle far away when no push is needed.
  function automatic void steer(int sx, output int px, output int py);
    int sy;
    px = FAR; py = FAR;
    if (m_mode != M_PLAY) return;
    sy = (m_vy > 0) ? 1 : -1;
    if (m_vy > 0 && m_y > 460) sy = -1;
    else if (m_vy < 0 && m_y < 300) sy = 1;
    if ((m_vx > 0) != (sx > 0) || (m_vy > 0) != (sy > 0)) begin
      px = (sx > 0) ? ((m_x >= 30) ? m_x - 30 : 0) : m_x + 30;
      py = (sy > 0) ? ((m_y >= 30) ? m_y - 30 : 0) : m_y + 30;
    end
  endfunction

  // One video frame: vsync rises for one cycle; g1/g2 capture goal in the
  // tick-result cycle and the cycle after. stray pulses start between ticks.
  task automatic frame(input bit st, input int px, input int py, input bit stray);
    bus.start = st; bus.paddle_xpos = 12'(px); bus.paddle_ypos = 12'(py);
    @(negedge clk); bus.vsync_in = 1'b1;
    @(posedge clk); #1; model_tick(st, px, py); g1 = bus.goal;
    @(negedge clk); bus.vsync_in = 1'b0; bus.start = stray;
    @(posedge clk); #1; g2 = bus.goal;
    @(negedge clk); bus.start = 1'b0;
  endtask

  // Reset with a coincident vsync edge and start request, both to be ignored.
  task automatic do_reset();
    @(negedge clk); rst = 1'b1; bus.vsync_in = 1'b1; bus.start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; bus.vsync_in = 1'b0; bus.start = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.puck_xpos !== 12'd512) begin errors++; $display("FAIL reset_x got %0d want 512", bus.puck_xpos); end
    checks++; if (bus.puck_ypos !== 12'd384) begin errors++; $display("FAIL reset_y got %0d want 384", bus.puck_ypos); end
    checks++; if (bus.score_p1 !== 3'd0 || bus.score_p2 !== 3'd0) begin errors++; $display("FAIL reset_score got %0d/%0d want 0/0", bus.score_p1, bus.score_p2); end
    checks++; if (bus.goal !== 1'b0 || bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", bus.goal, bus.game_over); end
    for (int i = 0; i < 3; i++) begin
      frame(0, FAR, FAR, 1);
      checks++; if (bus.puck_xpos !== 12'd512 || bus.puck_ypos !== 12'd384) begin errors++; $display("FAIL idle_pos got %0d,%0d want 512,384", bus.puck_xpos, bus.puck_ypos); end
      checks++; if (bus.score_p1 !== 3'd0 || bus.score_p2 !== 3'd0 || bus.game_over !== 1'b0) begin errors++; $display("FAIL idle_status got %0d/%0d/%b want 0/0/0", bus.score_p1, bus.score_p2, bus.game_over); end
    end
  endtask

  task automatic test_serve();
    for (int i = 0; i < 11; i++) begin
      frame(1, 100, 100, 0);
      checks++; if (bus.puck_xpos !== 12'(m_x) || bus.puck_ypos !== 12'(m_y)) begin errors++; $display("FAIL serve_pos got %0d,%0d want %0d,%0d", bus.puck_xpos, bus.puck_ypos, m_x, m_y); end
    end
    checks++; if (bus.puck_xpos !== 12'd552 || bus.puck_ypos !== 12'd424) begin errors++; $display("FAIL serve_end got %0d,%0d want 552,424", bus.puck_xpos, bus.puck_ypos); end
  endtask

  task automatic test_wall();
    for (int n = 0; n < 200 && m_y != 748; n++) begin
      frame(0, FAR, FAR, 0);
      checks++; if (bus.puck_xpos !== 12'(m_x) || bus.puck_ypos !== 12'(m_y)) begin errors++; $display("FAIL wall_run got %0d,%0d want %0d,%0d", bus.puck_xpos, bus.puck_ypos, m_x, m_y); end
    end
    checks++; if (bus.puck_ypos !== 12'd748) begin errors++; $display("FAIL wall_reach got %0d want 748", bus.puck_ypos); end
    frame(0, FAR, FAR, 0);
    checks++; if (bus.puck_ypos !== 12'd751 || bus.puck_xpos !== 12'd880) begin errors++; $display("FAIL wall_clamp got %0d,%0d want 880,751", bus.puck_xpos, bus.puck_ypos); end
    frame(0, FAR, FAR, 0);
    checks++; if (bus.puck_ypos !== 12'd747 || bus.puck_xpos !== 12'd884) begin errors++; $display("FAIL wall_reflect got %0d,%0d want 884,747", bus.puck_xpos, bus.puck_ypos); end
  endtask

  task automatic test_paddle();
    int px0, py0;
    px0 = m_x; py0 = m_y;
    frame(0, px0 + 30, py0, 0);
    checks++; if (bus.puck_xpos !== 12'(px0) || bus.puck_ypos !== 12'(py0)) begin errors++; $display("FAIL paddle_hold got %0d,%0d want %0d,%0d", bus.puck_xpos, bus.puck_ypos, px0, py0); end
    frame(0, FAR, FAR, 0);
    checks++; if (bus.puck_xpos !== 12'(px0 - 4) || bus.puck_ypos !== 12'(py0 + 4)) begin errors++; $display("FAIL paddle_reflect got %0d,%0d want %0d,%0d", bus.puck_xpos, bus.puck_ypos, px0 - 4, py0 + 4); end
  endtask

  task automatic test_left_goal();
    int px, py;
    bit hit;
    hit = 0;
    for (int n = 0; n < 400 && !hit; n++) begin
      steer(-1, px, py);
      frame(0, px, py, 0);
      hit = m_goal;
      checks++; if (bus.puck_xpos !== 12'(m_x) || bus.puck_ypos !== 12'(m_y)) begin errors++; $display("FAIL lgoal_run got %0d,%0d want %0d,%0d", bus.puck_xpos, bus.puck_ypos, m_x, m_y); end
    end
    checks++; if (g1 !== 1'b1 || g2 !== 1'b0) begin errors++; $display("FAIL lgoal_pulse got %b%b want 10", g1, g2); end
    checks++; if (bus.score_p2 !== 3'd1 || bus.score_p1 !== 3'd0) begin errors++; $display("FAIL lgoal_score got %0d/%0d want 0/1", bus.score_p1, bus.score_p2); end
    checks++; if (bus.puck_xpos !== 12'd512 || bus.puck_ypos !== 12'd384) begin errors++; $display("FAIL lgoal_centre got %0d,%0d want 512,384", bus.puck_xpos, bus.puck_ypos); end
    for (int i = 0; i < 60; i++) begin
      frame(0, FAR, FAR, 0);
      checks++; if (bus.puck_xpos !== 12'd512 || bus.puck_ypos !== 12'd384 || g1 !== 1'b0) begin errors++; $display("FAIL lgoal_hold got %0d,%0d,%b want 512,384,0", bus.puck_xpos, bus.puck_ypos, g1); end
    end
    frame(0, FAR, FAR, 0);
    checks++; if (bus.puck_xpos !== 12'd508 || bus.puck_ypos !== 12'd388) begin errors++; $display("FAIL lgoal_serve got %0d,%0d want 508,388", bus.puck_xpos, bus.puck_ypos); end
  endtask

  task automatic test_random();
    int px, py, r;
    bit st;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 100); px = m_x + r - 50; if (px < 0) px = 0;
        r = $urandom_range(0, 100); py = m_y + r - 50; if (py < 0) py = 0;
      end else begin
        px = FAR; py = FAR;
      end
      st = ($urandom_range(0, 5) == 0);
      frame(st, px, py, $urandom_range(0, 3) == 0);
      checks++; if (bus.puck_xpos !== 12'(m_x) || bus.puck_ypos !== 12'(m_y)) begin errors++; $display("FAIL rand_pos got %0d,%0d want %0d,%0d", bus.puck_xpos, bus.puck_ypos, m_x, m_y); end
      checks++; if (bus.score_p1 !== 3'(m_s1) || bus.score_p2 !== 3'(m_s2)) begin errors++; $display("FAIL rand_score got %0d/%0d want %0d/%0d", bus.score_p1, bus.score_p2, m_s1, m_s2); end
      checks++; if (g1 !== m_goal || g2 !== 1'b0 || bus.game_over !== (m_mode == M_OVER)) begin errors++; $display("FAIL rand_flags got %b%b%b want %b0%b", g1, g2, bus.game_over, m_goal, m_mode == M_OVER); end
    end
  endtask

  task automatic test_game_over();
    int px, py;
    bit hit;
    do_reset();
    frame(1, FAR, FAR, 0);
    for (int g = 1; g <= 7; g++) begin
      hit = 0;
      for (int n = 0; n < 500 && !hit; n++) begin
        steer(1, px, py);
        frame(0, px, py, 0);
        hit = m_goal;
        checks++; if (bus.puck_xpos !== 12'(m_x) || bus.puck_ypos !== 12'(m_y)) begin errors++; $display("FAIL go_run got %0d,%0d want %0d,%0d", bus.puck_xpos, bus.puck_ypos, m_x, m_y); end
      end
      checks++; if (bus.score_p1 !== 3'(g) || bus.score_p2 !== 3'd0 || g1 !== 1'b1 || g2 !== 1'b0) begin errors++; $display("FAIL go_goal got %0d/%0d pulse %b%b want %0d/0 pulse 10", bus.score_p1, bus.score_p2, g1, g2, g); end
    end
    for (int i = 0; i < 59; i++) begin
      frame(0, FAR, FAR, 0);
      checks++; if (bus.game_over !== 1'b0 || bus.puck_xpos !== 12'd512) begin errors++; $display("FAIL go_hold got %b,%0d want 0,512", bus.game_over, bus.puck_xpos); end
    end
    for (int i = 0; i < 4; i++) begin
      frame(0, FAR, FAR, 1);
      checks++; if (bus.game_over !== 1'b1 || bus.score_p1 !== 3'd7 || bus.puck_xpos !== 12'd512 || bus.puck_ypos !== 12'd384) begin errors++; $display("FAIL go_over got %b,%0d,%0d,%0d want 1,7,512,384", bus.game_over, bus.score_p1, bus.puck_xpos, bus.puck_ypos); end
    end
    frame(1, FAR, FAR, 0);
    checks++; if (bus.game_over !== 1'b0 || bus.score_p1 !== 3'd0 || bus.score_p2 !== 3'd0) begin errors++; $display("FAIL go_restart got %b,%0d/%0d want 0,0/0", bus.game_over, bus.score_p1, bus.score_p2); end
    frame(0, FAR, FAR, 0);
    checks++; if (bus.puck_xpos !== 12'd516 || bus.puck_ypos !== 12'd388) begin errors++; $display("FAIL go_serve got %0d,%0d want 516,388", bus.puck_xpos, bus.puck_ypos); end
  endtask

  task automatic test_reset_mid_hold();
    int px, py;
    bit hit;
    hit = 0;
    for (int n = 0; n < 500 && !hit; n++) begin
      steer(1, px, py);
      frame(0, px, py, 0);
      hit = m_goal;
    end
    checks++; if (bus.score_p1 !== 3'd1 || g1 !== 1'b1) begin errors++; $display("FAIL rh_goal got %0d,%b want 1,1", bus.score_p1, g1); end
    repeat (20) frame(0, FAR, FAR, 0);
    do_reset();
    checks++; if (bus.puck_xpos !== 12'd512 || bus.puck_ypos !== 12'd384) begin errors++; $display("FAIL rh_pos got %0d,%0d want 512,384", bus.puck_xpos, bus.puck_ypos); end
    checks++; if (bus.score_p1 !== 3'd0 || bus.game_over !== 1'b0 || bus.goal !== 1'b0) begin errors++; $display("FAIL rh_status got %0d,%b,%b want 0,0,0", bus.score_p1, bus.game_over, bus.goal); end
    frame(0, FAR, FAR, 1);
    checks++; if (bus.puck_xpos !== 12'd512 || bus.puck_ypos !== 12'd384) begin errors++; $display("FAIL rh_idle got %0d,%0d want 512,384", bus.puck_xpos, bus.puck_ypos); end
    frame(1, FAR, FAR, 0);
    frame(0, FAR, FAR, 0);
    checks++; if (bus.puck_xpos !== 12'd516 || bus.puck_ypos !== 12'd388) begin errors++; $display("FAIL rh_serve got %0d,%0d want 516,388", bus.puck_xpos, bus.puck_ypos); end
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.vsync_in = 1'b0;
    bus.start = 1'b0;
    bus.paddle_xpos = 12'(FAR);
    bus.paddle_ypos = 12'(FAR);
    model_reset();
    test_reset();
    test_serve();
    test_wall();
    test_paddle();
    test_left_goal();
    test_random();
    test_game_over();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
